sram_axi_burst_ctrl: RTL

//  Burst front-end for the SRAM_AXI 512x80 two-port buffer; drives its W_*/R_* ports directly.

---
 rtl/sram_axi_burst_ctrl.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/sram_axi_burst_ctrl.sv
// Burst front-end for a 512x80 two-port SRAM: independent write/read burst engines plus a
// read output FIFO that absorbs SRAM latency. Define SRAM_BURST_WRAP_EN to support WRAP bursts.
module sram_axi_burst_ctrl #(
  parameter int AW         = 9,
  parameter int DW         = 64,
  parameter int RD_LAT     = 1,
  parameter int OBUF_DEPTH = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          WCMD_VALID,
  output logic          WCMD_READY,
  input  logic [AW-1:0] WCMD_ADDR,
  input  logic [7:0]    WCMD_LEN,
  input  logic          WCMD_BURST,
  input  logic          WD_VALID,
  output logic          WD_READY,
  input  logic [DW-1:0] WD_DATA,
  input  logic [7:0]    WD_STRB,
  input  logic          WD_LAST,
  output logic          WRESP_VALID,
  input  logic          WRESP_READY,
  output logic          WRESP_ERR,
  input  logic          RCMD_VALID,
  output logic          RCMD_READY,
  input  logic [AW-1:0] RCMD_ADDR,
  input  logic [7:0]    RCMD_LEN,
  input  logic          RCMD_BURST,
  output logic          RD_VALID,
  input  logic          RD_READY,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_LAST,
  output logic [AW-1:0] SRAM_W_ADDR,
  output logic          SRAM_W_EN,
  output logic [7:0]    SRAM_WBYTE_EN,
  output logic [79:0]   SRAM_W_DATA,
  output logic [AW-1:0] SRAM_R_ADDR,
  output logic          SRAM_R_EN,
  input  logic [79:0]   SRAM_R_DATA
);

  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_ISSUE}        r_state_e;

  w_state_e      w_state_q, w_state_d;
  logic [AW-1:0] w_addr_q, w_addr_d, w_addr_nxt;
  logic [7:0]    w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic          w_err_q, w_err_d;

  r_state_e      r_state_q, r_state_d;
  logic [AW-1:0] r_addr_q, r_addr_d, r_addr_nxt;
  logic [7:0]    r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic          issue_last;

  logic [RD_LAT-1:0] pipe_vld_q, pipe_last_q;
  logic [DW:0]       fifo_mem [OBUF_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     fifo_cnt_q;
  logic              push, pop, room;
  int                inflight;

  logic unused_rdata;
  assign unused_rdata = ^SRAM_R_DATA[79:DW];

`ifdef SRAM_BURST_WRAP_EN
  logic w_burst_q, r_burst_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      w_burst_q <= 1'b0;
      r_burst_q <= 1'b0;
    end else begin
      if (WCMD_VALID && WCMD_READY) w_burst_q <= WCMD_BURST;
      if (RCMD_VALID && RCMD_READY) r_burst_q <= RCMD_BURST;
    end
  end

  // WRAP keeps the upper address bits and lets the low log2(LEN+1) bits roll over.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                               input logic [7:0]    len,
                                               input logic          wrap);
    logic [AW-1:0] mask;
    mask = AW'(len);
    if (wrap) return (addr & ~mask) | ((addr + AW'(1)) & mask);
    return addr + AW'(1);
  endfunction

  assign w_addr_nxt = next_addr(w_addr_q, w_len_q, w_burst_q);
  assign r_addr_nxt = next_addr(r_addr_q, r_len_q, r_burst_q);
`else
  logic unused_burst;
  assign unused_burst = WCMD_BURST ^ RCMD_BURST;
  assign w_addr_nxt   = w_addr_q + AW'(1);
  assign r_addr_nxt   = r_addr_q + AW'(1);
`endif

  // ---------------------------------------------------------------- write engine
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // NOTE: every output of an always_comb gets a default first so no path infers a latch.
  always_comb begin
    w_state_d     = w_state_q;
    w_addr_d      = w_addr_q;
    w_len_d       = w_len_q;
    w_cnt_d       = w_cnt_q;
    w_err_d       = w_err_q;
    WCMD_READY    = 1'b0;
    WD_READY      = 1'b0;
    WRESP_VALID   = 1'b0;
    WRESP_ERR     = 1'b0;
    SRAM_W_EN     = 1'b0;
    SRAM_W_ADDR   = '0;
    SRAM_WBYTE_EN = '0;
    SRAM_W_DATA   = '0;
    unique case (w_state_q)
      W_IDLE: begin
        WCMD_READY = 1'b1;
        if (WCMD_VALID) begin
          w_addr_d  = WCMD_ADDR;
          w_len_d   = WCMD_LEN;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        WD_READY = 1'b1;
        if (WD_VALID) begin
          SRAM_W_EN     = 1'b1;
          SRAM_W_ADDR   = w_addr_q;
          SRAM_WBYTE_EN = WD_STRB;
          SRAM_W_DATA   = {{(80-DW){1'b0}}, WD_DATA};
          w_addr_d      = w_addr_nxt;
          w_cnt_d       = w_cnt_q + 8'd1;
          // The count, not WD_LAST, ends the burst; LAST only flags agreement.
          if (w_cnt_q == w_len_q) begin
            w_err_d   = w_err_q | ~WD_LAST;
            w_state_d = W_RESP;
          end else begin
            w_err_d   = w_err_q | WD_LAST;
          end
        end
      end
      W_RESP: begin
        WRESP_VALID = 1'b1;
        WRESP_ERR   = w_err_q;
        if (WRESP_READY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- read engine
  always_comb begin
    inflight = 0;
    for (int i = 0; i < RD_LAT; i++) if (pipe_vld_q[i]) inflight++;
  end

  // Issue only when a FIFO slot is guaranteed for every outstanding SRAM read.
  assign room = (int'(fifo_cnt_q) + inflight) < OBUF_DEPTH;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state_q <= R_IDLE;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    RCMD_READY  = 1'b0;
    SRAM_R_EN   = 1'b0;
    SRAM_R_ADDR = '0;
    issue_last  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        RCMD_READY = 1'b1;
        if (RCMD_VALID) begin
          r_addr_d  = RCMD_ADDR;
          r_len_d   = RCMD_LEN;
          r_cnt_d   = '0;
          r_state_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (room) begin
          SRAM_R_EN   = 1'b1;
          SRAM_R_ADDR = r_addr_q;
          r_addr_d    = r_addr_nxt;
          r_cnt_d     = r_cnt_q + 8'd1;
          if (r_cnt_q == r_len_q) begin
            issue_last = 1'b1;
            r_state_d  = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- latency pipe + output FIFO
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push     = pipe_vld_q[RD_LAT-1];
  assign RD_VALID = (fifo_cnt_q != '0);
  assign pop      = RD_VALID & RD_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      pipe_vld_q  <= RD_LAT'({pipe_vld_q, SRAM_R_EN});
      pipe_last_q <= RD_LAT'({pipe_last_q, issue_last});
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the reset pointers and count make stale entries invisible.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr_q] <= {pipe_last_q[RD_LAT-1], SRAM_R_DATA[DW-1:0]};
  end

  always_comb begin
    RD_DATA = '0;
    RD_LAST = 1'b0;
    if (RD_VALID) {RD_LAST, RD_DATA} = fifo_mem[rd_ptr_q];
  end

endmodule
